byte_packer: RTL and testbench
==============================

# byte_packer

Assembles a stream of 8-bit bytes into wide words of NUM_BYTES lanes. It is the inverse of the word-to-byte splitter, and sits where byte-serial data returns from the serial side of the link. The first byte accepted fills lane 0 (bits [7:0]) and later bytes fill ascending lanes. A frame may end on a partial word, marked by lastIn, and the packer reports the valid lanes on a byte mask. The output side has a one-entry holding register with valid/ready backpressure.

## Interface
- NUM_BYTES, default 8: lanes per output word. Must be a power of two ≥ 2. The lane counter width is $clog2(NUM_BYTES).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- validIn  in  1  inData8 and lastIn are valid this cycle.
- inData8  in  8  input byte.
- lastIn  in  1  this byte ends the frame; emit the current word even if it is partial.
- readyIn  out  1  the packer accepts a byte this cycle. Combinational: readyIn = !validOut || readyOut.
- validOut  out  1  outData, byteMask and lastOut are valid.
- outData  out  NUM_BYTES*8  assembled word. Unfilled lanes are zero.
- byteMask  out  NUM_BYTES  bit i set means lane i holds a received byte.
- lastOut  out  1  this word ends a frame.
- readyOut  in  1  downstream accepts the output word this cycle.

## Operation
- A byte is accepted when validIn && readyIn. If readyIn is low, the byte is ignored and upstream must hold it.
- State consists of:
  - the assembly register (NUM_BYTES*8 bits)
  - the lane counter cnt
  - the output holding register (outData, byteMask, lastOut, validOut)
- Accepted byte, not completing: assembly lane cnt ← inData8, then cnt ← cnt+1.
- Accepted byte, completing (cnt == NUM_BYTES-1 or lastIn = 1):
  - outData ← assembly register with lane cnt replaced by inData8.
  - byteMask ← (1 << (cnt+1)) − 1.
  - lastOut ← lastIn.
  - validOut ← 1.
  - Assembly register ← 0, cnt ← 0.
- Output drain: if validOut && readyOut and no completing byte arrives that cycle, validOut ← 0. outData, byteMask and lastOut keep their values.
- Simultaneous drain and completion: the holding register reloads with the new word and validOut stays 1.
- Idle cycles (validIn = 0) mid-word: cnt and the assembly register hold indefinitely. There is no timeout.
- lastIn on the final lane: the word is full (byteMask all ones) and lastOut = 1.
- Stall: while validOut && !readyOut, readyIn = 0. Accepted partial bytes stay in the assembly register, and outData, byteMask and lastOut are held stable.
- Reset, including mid-word or mid-stall: the partial word is discarded and no residue appears in later words.

## Timing
- Reset values: validOut 0, outData 0, byteMask 0, lastOut 0, cnt 0, assembly register 0. readyIn is therefore 1 out of reset.
- Latency: when the completing byte is accepted at edge N, validOut is 1 from edge N until the word is drained.
- No combinational path from inData8, validIn or lastIn to any output.
- readyIn depends combinationally on readyOut only, through validOut.
- Throughput:
  - 1 byte per clock with readyOut held at 1.
  - A full word every NUM_BYTES cycles, with validOut high for 1 cycle per word.
  - lastIn on every byte gives one word per cycle, with validOut held high.
- A held word may drain on the first cycle validOut is high; the bench must not assume a minimum hold time.

## Test plan
- Continuous full word: after reset, send bytes 0x11, 0x22, …, 0x88 on consecutive cycles with readyOut = 1 → after the 8th edge, validOut = 1 for exactly 1 cycle with outData = 0x8877665544332211, byteMask = 0xFF, lastOut = 0.
- Partial frame: send 0xAA, 0xBB, 0xCC with lastIn on 0xCC → outData = 0x0000000000CCBBAA, byteMask = 0x07, lastOut = 1. A following byte 0xDD lands in lane 0 of the next word, and that word carries no leftover 0xAA/0xBB/0xCC.
- Backpressure: hold readyOut = 0 and complete word 0x0807060504030201 → validOut stays 1 and readyIn = 0. Bytes presented during the stall are not accepted, and outData is stable for 10 cycles. Raise readyOut → validOut drops next edge, readyIn returns to 1, and the held byte is then accepted into lane 0.
- Gapped input: the same 8 bytes as the first scenario, with 0–3 random idle cycles between them → identical word and mask. validOut rises one edge after the 8th byte.
- Reset mid-word: accept 5 bytes, then pulse reset → all outputs 0 and readyIn = 1. Then send 0x01…0x08 → outData = 0x0807060504030201, byteMask = 0xFF.
- Back-to-back single-byte frames: lastIn = 1 on every byte (0x10, 0x20, 0x30) with readyOut = 1 → validOut high for 3 consecutive cycles. outData takes the values 0x10, 0x20, 0x30, each with byteMask = 0x01 and lastOut = 1, with no word dropped.

Source files
------------

// File: rtl/byte_packer.sv
// Byte-to-word packer: collects 8-bit bytes into NUM_BYTES-lane words, flushing
// early on lastIn, with a one-entry valid/ready output holding register.
module byte_packer #(
    parameter int NUM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   validIn,
    input  logic [7:0]             inData8,
    input  logic                   lastIn,
    output logic                   readyIn,
    output logic                   validOut,
    output logic [NUM_BYTES*8-1:0] outData,
    output logic [NUM_BYTES-1:0]   byteMask,
    output logic                   lastOut,
    input  logic                   readyOut
);

    localparam int CW = $clog2(NUM_BYTES);
    localparam int WW = NUM_BYTES * 8;
    localparam logic [CW-1:0] LAST_LANE = CW'(NUM_BYTES - 1);

    // Lanes 0..c inclusive are occupied once lane c has been written.
    function automatic logic [NUM_BYTES-1:0] fill_mask(input logic [CW-1:0] c);
        logic [NUM_BYTES-1:0] m;
        m = {NUM_BYTES{1'b0}};
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (CW'(i) <= c) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [WW-1:0]        asm_r;
    logic [CW-1:0]        cnt_r;
    logic [WW-1:0]        out_data_r;
    logic [NUM_BYTES-1:0] byte_mask_r;
    logic                 last_out_r;
    logic                 valid_out_r;

    logic                 ready_s;
    logic                 accept_s;
    logic                 complete_s;
    logic [WW-1:0]        merged_s;

    // Handshake decode; readyIn only sees readyOut through the held valid.
    always_comb begin
        ready_s    = !valid_out_r || readyOut;
        accept_s   = validIn && ready_s;
        complete_s = accept_s && ((cnt_r == LAST_LANE) || lastIn);
    end

    // Assembly word with the incoming byte dropped into lane cnt.
    always_comb begin
        merged_s = asm_r;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (cnt_r == CW'(i)) begin
                merged_s[i*8 +: 8] = inData8;
            end else begin
                merged_s[i*8 +: 8] = asm_r[i*8 +: 8];
            end
        end
    end

    // Assembly register and lane counter; cleared whenever a word is emitted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_r <= {WW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (complete_s) begin
            asm_r <= {WW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            asm_r <= merged_s;
            cnt_r <= cnt_r + CW'(1);
        end else begin
            asm_r <= asm_r;
            cnt_r <= cnt_r;
        end
    end

    // Output holding register; a completion in the drain cycle reloads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r  <= {WW{1'b0}};
            byte_mask_r <= {NUM_BYTES{1'b0}};
            last_out_r  <= 1'b0;
            valid_out_r <= 1'b0;
        end else if (complete_s) begin
            out_data_r  <= merged_s;
            byte_mask_r <= fill_mask(cnt_r);
            last_out_r  <= lastIn;
            valid_out_r <= 1'b1;
        end else if (valid_out_r && readyOut) begin
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= valid_out_r;
        end
    end

    assign readyIn  = ready_s;
    assign validOut = valid_out_r;
    assign outData  = out_data_r;
    assign byteMask = byte_mask_r;
    assign lastOut  = last_out_r;

endmodule

// File: tb/tb_byte_packer.sv
// Directed self-checking bench for byte_packer (NUM_BYTES = 8).
module tb_byte_packer;

    logic        clk;
    logic        reset;
    logic        validIn;
    logic [7:0]  inData8;
    logic        lastIn;
    logic        readyIn;
    logic        validOut;
    logic [63:0] outData;
    logic [7:0]  byteMask;
    logic        lastOut;
    logic        readyOut;

    int checks_r = 0;
    int errors_r = 0;

    byte_packer #(.NUM_BYTES(8)) dut (
        .clk(clk), .reset(reset), .validIn(validIn), .inData8(inData8),
        .lastIn(lastIn), .readyIn(readyIn), .validOut(validOut),
        .outData(outData), .byteMask(byteMask), .lastOut(lastOut),
        .readyOut(readyOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        validIn = 1'b1;
        inData8 = d;
        lastIn  = l;
        tick();
        validIn = 1'b0;
        lastIn  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {63'd0, validOut}, 64'd0);
        check({tag, "_data"},  outData, 64'd0);
        check({tag, "_mask"},  {56'd0, byteMask}, 64'd0);
        check({tag, "_last"},  {63'd0, lastOut}, 64'd0);
        check({tag, "_ready"}, {63'd0, readyIn}, 64'd1);
    endtask

    logic [63:0] held_s;

    initial begin
        reset    = 1'b1;
        validIn  = 1'b0;
        inData8  = 8'h00;
        lastIn   = 1'b0;
        readyOut = 1'b1;
        #2;
        check_reset_state("rst");
        tick();
        reset = 1'b0;

        // Continuous full word
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h11 * (i + 1)), 1'b0);
            if (i < 7) check("full_vpre", {63'd0, validOut}, 64'd0);
        end
        check("full_valid", {63'd0, validOut}, 64'd1);
        check("full_data", outData, 64'h8877665544332211);
        check("full_mask", {56'd0, byteMask}, 64'hFF);
        check("full_last", {63'd0, lastOut}, 64'd0);
        tick();
        check("full_drain", {63'd0, validOut}, 64'd0);

        // Partial frame, then next byte with simultaneous drain
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check("part_valid", {63'd0, validOut}, 64'd1);
        check("part_data", outData, 64'h0000000000CCBBAA);
        check("part_mask", {56'd0, byteMask}, 64'h07);
        check("part_last", {63'd0, lastOut}, 64'd1);
        send(8'hDD, 1'b1);
        check("next_valid", {63'd0, validOut}, 64'd1);
        check("next_data", outData, 64'h00000000000000DD);
        check("next_mask", {56'd0, byteMask}, 64'h01);
        tick();
        check("next_drain", {63'd0, validOut}, 64'd0);

        // Backpressure
        readyOut = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0);
        check("bp_valid", {63'd0, validOut}, 64'd1);
        check("bp_ready", {63'd0, readyIn}, 64'd0);
        check("bp_data", outData, 64'h0807060504030201);
        validIn = 1'b1;
        inData8 = 8'h99;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_stable", outData, 64'h0807060504030201);
            check("bp_hold_valid", {63'd0, validOut}, 64'd1);
            check("bp_hold_ready", {63'd0, readyIn}, 64'd0);
        end
        readyOut = 1'b1;
        #1;
        check("bp_ready_comb", {63'd0, readyIn}, 64'd1);
        tick();
        validIn = 1'b0;
        check("bp_drop", {63'd0, validOut}, 64'd0);
        check("bp_ready_back", {63'd0, readyIn}, 64'd1);
        send(8'h9A, 1'b1);
        check("bp_lane0_data", outData, 64'h0000000000009A99);
        check("bp_lane0_mask", {56'd0, byteMask}, 64'h03);
        tick();

        // Gapped input
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_idle", {63'd0, validOut}, 64'd0);
            end
            send(8'(8'h11 * (i + 1)), 1'b0);
        end
        check("gap_valid", {63'd0, validOut}, 64'd1);
        check("gap_data", outData, 64'h8877665544332211);
        check("gap_mask", {56'd0, byteMask}, 64'hFF);
        tick();

        // Reset mid-word
        for (int i = 0; i < 5; i++) send(8'(8'hE1 + i), 1'b0);
        reset = 1'b1;
        #2;
        check_reset_state("midrst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0);
        check("midrst_data", outData, 64'h0807060504030201);
        check("midrst_mask", {56'd0, byteMask}, 64'hFF);
        tick();

        // Back-to-back single-byte frames
        for (int i = 0; i < 3; i++) begin
            held_s = 64'(8'h10 * (i + 1));
            send(held_s[7:0], 1'b1);
            check("b2b_valid", {63'd0, validOut}, 64'd1);
            check("b2b_data", outData, held_s);
            check("b2b_mask", {56'd0, byteMask}, 64'h01);
            check("b2b_last", {63'd0, lastOut}, 64'd1);
        end
        tick();
        check("b2b_drain", {63'd0, validOut}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
